// File: rtl/apb_master_bridge_mc.sv
// Multi-completer APB4 requester bridge: valid/ready command port in, address-decoded
// psel, wait-state timeout, registered single-cycle response out.
//
// state  | meaning
// IDLE   | no transfer in flight, ready for a command
// SETUP  | psel asserted, penable low, fields stable
// ACCESS | psel and penable asserted, waiting for pready, decode error or timeout
module apb_master_bridge_mc #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int SEL_LSB = 12,
  parameter int TIMEOUT = 16
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [DATA_W-1:0]         req_wdata,
  input  logic [DATA_W/8-1:0]       req_strb,
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [NUM_SLV-1:0]        psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  output logic [DATA_W/8-1:0]       pstrb,
  input  logic [NUM_SLV*DATA_W-1:0] prdata,
  input  logic [NUM_SLV-1:0]        pready,
  input  logic [NUM_SLV-1:0]        pslverr
);

  localparam int STRB_W = DATA_W / 8;
  localparam int SEL_W  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    req_idx, idx_q;
  logic                req_derr, derr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                write_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   strb_q;
  logic [CNT_W-1:0]    wcnt_q;
  logic                sel_ready, sel_err;
  logic [DATA_W-1:0]   sel_rdata;
  logic                in_access, tout, done, accept;
  logic                rsp_valid_q, rsp_err_q;
  logic [DATA_W-1:0]   rsp_rdata_q;

  generate
    if (NUM_SLV > 1) begin : g_dec
      assign req_idx = req_addr[SEL_LSB +: SEL_W];
    end else begin : g_nodec
      assign req_idx = '0;
    end
  endgenerate

  // Only a non-power-of-two NUM_SLV can leave index codes without a completer.
  assign req_derr = (int'(req_idx) >= NUM_SLV);

  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (!derr_q && idx_q == SEL_W'(i)) begin
        sel_ready = pready[i];
        sel_err   = pslverr[i];
        sel_rdata = prdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign in_access = (state_q == ACCESS);
  assign tout      = (TIMEOUT > 0) && in_access && !derr_q && !sel_ready && (wcnt_q == CNT_LAST);
  assign done      = in_access && (sel_ready || derr_q || tout);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = SETUP;
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (done) begin
          req_ready = 1'b1;
          state_d   = req_valid ? SETUP : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      strb_q      <= '0;
      idx_q       <= '0;
      derr_q      <= 1'b0;
      wcnt_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr;
        write_q <= req_write;
        wdata_q <= req_wdata;
        strb_q  <= req_write ? req_strb : '0;
        idx_q   <= req_idx;
        derr_q  <= req_derr;
      end
      if (state_q == SETUP)        wcnt_q <= '0;
      else if (in_access && !done) wcnt_q <= wcnt_q + CNT_W'(1);
      rsp_valid_q <= done;
      rsp_err_q   <= done && (derr_q || tout || (sel_ready && sel_err));
      rsp_rdata_q <= (done && !write_q && sel_ready && !sel_err) ? sel_rdata : '0;
    end
  end

  always_comb begin
    psel = '0;
    if (state_q != IDLE && !derr_q) begin
      for (int i = 0; i < NUM_SLV; i++) psel[i] = (idx_q == SEL_W'(i));
    end
  end

  assign penable   = in_access;
  assign pwrite    = write_q;
  assign paddr     = addr_q;
  assign pwdata    = wdata_q;
  assign pstrb     = strb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_bridge_mc.sv
// Directed bench for apb_master_bridge_mc: vector table of single transfers against a
// wait-state completer model, plus back-to-back, decode-error and reset sequences.
module tb_apb_master_bridge_mc;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  always #5 pclk = ~pclk;

  // four-completer instance
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_strb = '0;
  logic        req_ready, rsp_valid, rsp_err, penable, pwrite;
  logic [31:0] rsp_rdata, paddr, pwdata;
  logic [3:0]  psel, pstrb, pready, pslverr;
  logic [127:0] prdata;

  // three-completer instance for the decode-error case
  logic        req3_valid = 1'b0, req3_write = 1'b0;
  logic [31:0] req3_addr = '0;
  logic        req3_ready, rsp3_valid, rsp3_err, penable3, pwrite3;
  logic [31:0] rsp3_rdata, paddr3, pwdata3;
  logic [2:0]  psel3;
  logic [3:0]  pstrb3;
  logic [95:0] prdata3 = {32'hCAFEF00D, 32'h11111111, 32'h00000000};

  apb_master_bridge_mc #(.NUM_SLV(4), .TIMEOUT(16)) dut (
    .pclk(pclk), .preset(preset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr));

  apb_master_bridge_mc #(.NUM_SLV(3), .TIMEOUT(16)) dut3 (
    .pclk(pclk), .preset(preset), .req_valid(req3_valid), .req_ready(req3_ready),
    .req_write(req3_write), .req_addr(req3_addr), .req_wdata(32'h0), .req_strb(4'h0),
    .rsp_valid(rsp3_valid), .rsp_rdata(rsp3_rdata), .rsp_err(rsp3_err),
    .psel(psel3), .penable(penable3), .pwrite(pwrite3), .paddr(paddr3), .pwdata(pwdata3),
    .pstrb(pstrb3), .prdata(prdata3), .pready(3'b111), .pslverr(3'b000));

  // completer model: selected slave raises pready after waits_cfg ACCESS cycles;
  // unselected slaves present ready, error and junk data that must be ignored
  int          waits_cfg = 0;
  logic        err_cfg = 1'b0;
  logic [31:0] rdata_cfg = '0;
  int          acc_cnt = 0;

  always @(posedge pclk) begin
    if (penable && ((psel & pready) == 4'b0)) acc_cnt <= acc_cnt + 1;
    else                                      acc_cnt <= 0;
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pready[i]  = psel[i] ? (penable && acc_cnt >= waits_cfg) : 1'b1;
      pslverr[i] = psel[i] ? err_cfg : 1'b1;
      prdata[i*32 +: 32] = psel[i] ? rdata_cfg : (32'hBAD00000 | 32'(i));
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;
    logic        serr;
    logic [31:0] rdata;
    logic [3:0]  e_psel;
    logic [3:0]  e_strb;
    int          e_acc;
    logic        e_err;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic do_xfer(input vec_t v);
    int acc;
    int cyc;
    @(negedge pclk);
    req_valid = 1'b1; req_write = v.wr; req_addr = v.addr;
    req_wdata = v.wdata; req_strb = v.strb;
    waits_cfg = v.waits; err_cfg = v.serr; rdata_cfg = v.rdata;
    chk("ready_idle", 32'(req_ready), 32'd1);
    @(negedge pclk);
    req_valid = 1'b0;
    chk("setup_psel", 32'(psel), 32'(v.e_psel));
    chk("setup_penable", 32'(penable), 32'd0);
    chk("setup_paddr", paddr, v.addr);
    chk("setup_pwrite", 32'(pwrite), 32'(v.wr));
    chk("setup_pstrb", 32'(pstrb), 32'(v.e_strb));
    if (v.wr) chk("setup_pwdata", pwdata, v.wdata);
    acc = 0;
    cyc = 1;
    @(negedge pclk);
    cyc++;
    while (!rsp_valid && cyc < 60) begin
      if (penable) begin
        acc++;
        if (acc == 1) chk("access_psel", 32'(psel), 32'(v.e_psel));
      end
      @(negedge pclk);
      cyc++;
    end
    chk("rsp_seen", 32'(rsp_valid), 32'd1);
    chk("access_cycles", 32'(acc), 32'(v.e_acc));
    chk("rsp_latency", 32'(cyc), 32'(v.e_acc + 2));
    chk("rsp_err", 32'(rsp_err), 32'(v.e_err));
    chk("rsp_rdata", rsp_rdata, v.e_rdata);
    chk("after_psel", 32'(psel), 32'd0);
    chk("after_penable", 32'(penable), 32'd0);
    @(negedge pclk);
    chk("rsp_pulse", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int r1, r2;
    logic any_rsp;
    //            wr    addr          wdata         strb  wt   serr  rdata         psel   strb  acc err  rdata
    vecs[0] = '{1'b1, 32'h00001004, 32'hDEADBEEF, 4'hF, 0,   1'b0, 32'h0,        4'b0010, 4'hF, 1,  1'b0, 32'h0};
    vecs[1] = '{1'b0, 32'h00002000, 32'h0,        4'hF, 3,   1'b0, 32'h12345678, 4'b0100, 4'h0, 4,  1'b0, 32'h12345678};
    vecs[2] = '{1'b0, 32'h00001008, 32'h0,        4'h0, 0,   1'b1, 32'h55AA55AA, 4'b0010, 4'h0, 1,  1'b1, 32'h0};
    vecs[3] = '{1'b1, 32'h00000010, 32'h0BADF00D, 4'h3, 1,   1'b0, 32'h0,        4'b0001, 4'h3, 2,  1'b0, 32'h0};
    vecs[4] = '{1'b0, 32'h00003FFC, 32'h0,        4'h0, 0,   1'b0, 32'hA5A5A5A5, 4'b1000, 4'h0, 1,  1'b0, 32'hA5A5A5A5};
    vecs[5] = '{1'b0, 32'h00000000, 32'h0,        4'h0, 100, 1'b0, 32'h77777777, 4'b0001, 4'h0, 16, 1'b1, 32'h0};

    repeat (3) @(negedge pclk);
    preset = 1'b0;
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_paddr", paddr, 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    foreach (vecs[i]) do_xfer(vecs[i]);

    // back-to-back writes to slaves 0 and 3 with req_valid held
    waits_cfg = 0; err_cfg = 1'b0;
    @(negedge pclk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0; req_wdata = 32'h11112222; req_strb = 4'hF;
    @(negedge pclk);
    chk("b2b_setup0", 32'(psel), 32'b0001);
    req_addr = 32'h3000; req_wdata = 32'h33334444; req_strb = 4'hC;
    @(negedge pclk);
    chk("b2b_access0", 32'({psel, penable}), 32'b00011);
    chk("b2b_ready_done", 32'(req_ready), 32'd1);
    r1 = 0; r2 = 0;
    @(negedge pclk);
    req_valid = 1'b0;
    chk("b2b_setup3", 32'({psel, penable}), 32'b10000);
    chk("b2b_rsp1", 32'(rsp_valid), 32'd1);
    chk("b2b_paddr3", paddr, 32'h3000);
    @(negedge pclk);
    chk("b2b_access3", 32'({psel, penable}), 32'b10001);
    chk("b2b_pwdata3", pwdata, 32'h33334444);
    chk("b2b_gap", 32'(rsp_valid), 32'd0);
    @(negedge pclk);
    chk("b2b_rsp2", 32'(rsp_valid), 32'd1);
    chk("b2b_idle", 32'({psel, penable}), 32'd0);

    // decode error on the three-completer instance, then a normal read there
    @(negedge pclk);
    req3_valid = 1'b1; req3_write = 1'b0; req3_addr = 32'h3000;
    @(negedge pclk);
    req3_valid = 1'b0;
    chk("derr_setup_psel", 32'(psel3), 32'd0);
    @(negedge pclk);
    chk("derr_access", 32'({psel3, penable3}), 32'b0001);
    @(negedge pclk);
    chk("derr_rsp", 32'({rsp3_valid, rsp3_err}), 32'b11);
    chk("derr_rdata", rsp3_rdata, 32'h0);
    req3_valid = 1'b1; req3_addr = 32'h2000;
    @(negedge pclk);
    req3_valid = 1'b0;
    chk("n3_setup_psel", 32'(psel3), 32'b100);
    repeat (2) @(negedge pclk);
    chk("n3_rsp", 32'({rsp3_valid, rsp3_err}), 32'b10);
    chk("n3_rdata", rsp3_rdata, 32'hCAFEF00D);

    // reset while the completer is stalling
    waits_cfg = 100;
    @(negedge pclk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h1000;
    @(negedge pclk);
    req_valid = 1'b0;
    repeat (3) @(negedge pclk);
    chk("rst_mid_penable", 32'(penable), 32'd1);
    preset = 1'b1;
    @(negedge pclk);
    chk("rst_mid_out", 32'({psel, penable, rsp_valid}), 32'd0);
    chk("rst_mid_paddr", paddr, 32'd0);
    preset = 1'b0;
    any_rsp = 1'b0;
    repeat (4) begin
      @(negedge pclk);
      any_rsp = any_rsp | rsp_valid;
    end
    chk("rst_mid_no_rsp", 32'(any_rsp), 32'd0);
    do_xfer(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
